// File: rtl/mem_access_pkg.sv
// Shared types for the memory-access stage: RV32I load/store funct3 encodings,
// FSM state encoding, captured-op and MEM/WB record layouts, and an
// access-size decoder used by both the store-lane logic and load formatting.
package mem_access_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic { ST_IDLE = 1'b0, ST_BUSY = 1'b1 } state_e;

    typedef enum logic [1:0] { SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2 } size_e;

    // Memory op latched while the DMEM transaction is open.
    typedef struct packed {
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
        logic [4:0]  rd;
        logic        write_reg;
        logic        is_load;
        logic [31:0] alu_result;
    } op_t;

    // MEM/WB pipeline register contents.
    typedef struct packed {
        logic        use_mem;
        logic        write_reg;
        logic        misalign;
        logic [31:0] data;
        logic [31:0] alu_result;
        logic [4:0]  rd;
    } mwb_t;

    // Any funct3 that is not a legal size for the op kind falls back to a word.
    function automatic size_e access_size(input logic [2:0] f3, input logic is_store);
        size_e sz;
        sz = SZ_W;
        if (is_store) begin
            case (f3)
                F3_SB:   sz = SZ_B;
                F3_SH:   sz = SZ_H;
                default: sz = SZ_W;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: sz = SZ_B;
                F3_LH, F3_LHU: sz = SZ_H;
                default:       sz = SZ_W;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// DMEM request/acknowledge bus between the memory-access stage (master) and
// the data memory (slave).
interface mem_access_if #(
    parameter int ADDR_W = 32
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              ack;
    logic [31:0]       rdata;

    modport master (output req, we, addr, be, wdata, input ack, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_load_extract.sv
// Load formatting: selects the addressed byte/half of the returned word and
// sign- or zero-extends it to 32 bits. Purely combinational.
module mem_access_load_extract
    import mem_access_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select then extend; unsigned variants are the ones with funct3[2] set.
    always_comb begin
        byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o   = rdata_i;
        case (access_size(funct3_i, 1'b0))
            SZ_B:    data_o = funct3_i[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_H:    data_o = funct3_i[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/mem_access.sv
// Memory-access stage of the RV32 pipeline. Issues one DMEM request per load or
// store, stalls upstream until the ack, then hands the formatted result to the
// MEM/WB register. Optional macro MISALIGN_TRAP_EN: misaligned half/word
// accesses skip DMEM and raise misalign_o in MEM/WB instead.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         PIP_valid_i,
    input  logic         PIP_mem_read_i,
    input  logic         PIP_mem_write_i,
    input  logic [2:0]   PIP_funct3_i,
    input  logic [31:0]  PIP_alu_result_i,
    input  logic [31:0]  PIP_store_data_i,
    input  logic         PIP_write_reg_i,
    input  logic [4:0]   PIP_rd_i,
    output logic         stall_o,
    mem_access_if.master dmem,
    output logic         PIP_use_mem_o,
    output logic         PIP_write_reg_o,
    output logic [31:0]  PIP_DMEM_data_o,
    output logic [31:0]  PIP_alu_result_o,
    output logic [4:0]   PIP_rd_o,
    output logic         misalign_o
);
    state_e            state_q, state_d;
    op_t               op_q, op_d;
    mwb_t              mwb_q, mwb_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              mem_op;
    logic              misaligned;
    logic              stall_c;
    size_e             in_sz;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata;
    logic [31:0]       ld_data;

    assign mem_op = PIP_valid_i & (PIP_mem_read_i | PIP_mem_write_i);
    assign in_sz  = access_size(PIP_funct3_i, PIP_mem_write_i);

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((in_sz == SZ_H) && PIP_alu_result_i[0]) ||
                        ((in_sz == SZ_W) && (PIP_alu_result_i[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Store lane steering: enables follow the addressed lane, data is replicated.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = PIP_store_data_i;
        case (in_sz)
            SZ_B: begin
                st_be    = 4'b0001 << PIP_alu_result_i[1:0];
                st_wdata = {4{PIP_store_data_i[7:0]}};
            end
            SZ_H: begin
                st_be    = 4'b0011 << {PIP_alu_result_i[1], 1'b0};
                st_wdata = {2{PIP_store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    mem_access_load_extract u_load_extract (
        .funct3_i  (op_q.funct3),
        .addr_lo_i (op_q.addr_lo),
        .rdata_i   (dmem.rdata),
        .data_o    (ld_data)
    );

    // Next-state, DMEM request and MEM/WB contents; MEM/WB defaults to a bubble.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        mwb_d   = '0;
        stall_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_op && !misaligned) begin
                    stall_c           = 1'b1;
                    state_d           = ST_BUSY;
                    req_d             = 1'b1;
                    we_d              = PIP_mem_write_i;
                    addr_d            = {PIP_alu_result_i[ADDR_W-1:2], 2'b00};
                    be_d              = PIP_mem_write_i ? st_be : 4'b0000;
                    wdata_d           = PIP_mem_write_i ? st_wdata : 32'b0;
                    op_d.funct3       = PIP_funct3_i;
                    op_d.addr_lo      = PIP_alu_result_i[1:0];
                    op_d.rd           = PIP_rd_i;
                    op_d.write_reg    = PIP_write_reg_i;
                    op_d.is_load      = PIP_mem_read_i;
                    op_d.alu_result   = PIP_alu_result_i;
                end else if (mem_op) begin
                    mwb_d.misalign    = 1'b1;
                    mwb_d.alu_result  = PIP_alu_result_i;
                    mwb_d.rd          = PIP_rd_i;
                end else if (PIP_valid_i) begin
                    mwb_d.write_reg   = PIP_write_reg_i;
                    mwb_d.alu_result  = PIP_alu_result_i;
                    mwb_d.rd          = PIP_rd_i;
                end
            end
            ST_BUSY: begin
                stall_c = ~dmem.ack;
                if (dmem.ack) begin
                    state_d          = ST_IDLE;
                    req_d            = 1'b0;
                    mwb_d.use_mem    = op_q.is_load;
                    mwb_d.write_reg  = op_q.write_reg & op_q.is_load;
                    mwb_d.data       = op_q.is_load ? ld_data : 32'b0;
                    mwb_d.alu_result = op_q.alu_result;
                    mwb_d.rd         = op_q.rd;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, DMEM bus and MEM/WB registers; reset abandons any open request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            mwb_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'b0000;
            wdata_q <= 32'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            mwb_q   <= mwb_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    // Nothing is in flight while reset is held, so never stall upstream then.
    assign stall_o          = stall_c & ~reset;
    assign dmem.req         = req_q;
    assign dmem.we          = we_q;
    assign dmem.addr        = addr_q;
    assign dmem.be          = be_q;
    assign dmem.wdata       = wdata_q;
    assign PIP_use_mem_o    = mwb_q.use_mem;
    assign PIP_write_reg_o  = mwb_q.write_reg;
    assign PIP_DMEM_data_o  = mwb_q.data;
    assign PIP_alu_result_o = mwb_q.alu_result;
    assign PIP_rd_o         = mwb_q.rd;
    assign misalign_o       = mwb_q.misalign;
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a transaction-level model predicts each
// MEM/WB record and the cycle it must appear; a per-cycle compare process
// checks MEM/WB, while the driver tasks check the DMEM bus and stall.
module tb_mem_access;
    logic        clk = 1'b0;
    logic        reset;
    logic        valid, mrd, mwr, wr_i;
    logic [2:0]  f3;
    logic [31:0] alu_i, sd_i;
    logic [4:0]  rd_i;
    logic        stall, use_mem, wr_o, mis_o;
    logic [31:0] data_o, alu_o;
    logic [4:0]  rd_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit run   = 0;
    logic [3:0]  last_be;
    logic [31:0] last_wdata, last_addr;

    typedef struct {
        int          at;
        logic        wr, um, mis, chk_data;
        logic [31:0] data, alu;
        logic [4:0]  rd;
    } wb_t;
    wb_t exp_q[$];

    mem_access_if #(.ADDR_W(32)) bus ();

    mem_access #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .PIP_valid_i(valid), .PIP_mem_read_i(mrd), .PIP_mem_write_i(mwr),
        .PIP_funct3_i(f3), .PIP_alu_result_i(alu_i), .PIP_store_data_i(sd_i),
        .PIP_write_reg_i(wr_i), .PIP_rd_i(rd_i), .stall_o(stall), .dmem(bus),
        .PIP_use_mem_o(use_mem), .PIP_write_reg_o(wr_o), .PIP_DMEM_data_o(data_o),
        .PIP_alu_result_o(alu_o), .PIP_rd_o(rd_o), .misalign_o(mis_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---- model: sizes, lanes and load extension from the ISA rules ----
    function automatic int nbytes(input logic [2:0] f, input bit st);
        if (st) return (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : 4;
        return (f == 3'd0 || f == 3'd4) ? 1 : (f == 3'd1 || f == 3'd5) ? 2 : 4;
    endfunction

    function automatic int lane_off(input int n, input logic [31:0] a);
        int o;
        o = int'(a % 4);
        return (n == 4) ? 0 : o - (o % n);
    endfunction

    function automatic bit is_mis(input int n, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        return (n == 2 && a % 2 != 0) || (n == 4 && a % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [3:0] m_be(input int n, input logic [31:0] a);
        int v;
        v = ((1 << n) - 1) << lane_off(n, a);
        return 4'(v);
    endfunction

    function automatic logic [31:0] m_wd(input int n, input logic [31:0] d);
        if (n == 1) return {24'b0, d[7:0]} * 32'h0101_0101;
        if (n == 2) return {16'b0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
        int n;
        longint v;
        n = nbytes(f, 1'b0);
        v = longint'(w) >> (8 * lane_off(n, a));
        if (n < 4) begin
            v = v & ((64'd1 << (8 * n)) - 1);
            if (!(f == 3'd4 || f == 3'd5) && ((v >> (8 * n - 1)) & 1) == 1)
                v = v - (64'd1 << (8 * n));
        end
        return 32'(v);
    endfunction

    // ---- compare process: MEM/WB every cycle, against the expectation queue ----
    always @(negedge clk) begin
        if (run) begin
            if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                total++; bad++;
                $display("FAIL wb_missed: expected record at cycle %0d, now %0d", exp_q[0].at, cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                wb_t e;
                e = exp_q.pop_front();
                check("wb_write_reg", wr_o, e.wr);
                check("wb_use_mem", use_mem, e.um);
                check("wb_misalign", mis_o, e.mis);
                check("wb_alu", alu_o, e.alu);
                check("wb_rd", rd_o, e.rd);
                if (e.chk_data) check("wb_data", data_o, e.data);
            end else begin
                check("bubble_write_reg", wr_o, 1'b0);
                check("bubble_use_mem", use_mem, 1'b0);
                check("bubble_misalign", mis_o, 1'b0);
            end
        end
    end

    // ---- driver tasks ----
    task automatic do_idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            valid = 1'b0; mrd = 1'b1; mwr = 1'b0; wr_i = 1'b1; bus.ack = 1'b0;
            @(negedge clk);
            check("idle_req", bus.req, 1'b0);
            check("idle_stall", stall, 1'b0);
        end
    endtask

    task automatic do_alu(input logic [31:0] a, input logic [4:0] rd, input logic wr);
        wb_t e;
        @(posedge clk); #1;
        valid = 1'b1; mrd = 1'b0; mwr = 1'b0; alu_i = a; rd_i = rd; wr_i = wr; bus.ack = 1'b0;
        @(negedge clk);
        check("alu_stall", stall, 1'b0);
        check("alu_req", bus.req, 1'b0);
        e = '{at: cyc + 1, wr: wr, um: 1'b0, mis: 1'b0, chk_data: 1'b0, data: 32'b0, alu: a, rd: rd};
        exp_q.push_back(e);
    endtask

    task automatic do_mem(input bit ld, input logic [2:0] f, input logic [31:0] a, input logic [31:0] sd,
                          input logic wr, input logic [4:0] rd, input int nwait, input logic [31:0] rdata);
        int  n;
        wb_t e;
        n = nbytes(f, !ld);
        @(posedge clk); #1;
        valid = 1'b1; mrd = ld; mwr = !ld; f3 = f; alu_i = a; sd_i = sd; wr_i = wr; rd_i = rd;
        bus.ack = 1'b0;
        @(negedge clk);
        check("issue_req_low", bus.req, 1'b0);
        if (is_mis(n, a)) begin
            check("mis_stall", stall, 1'b0);
            e = '{at: cyc + 1, wr: 1'b0, um: 1'b0, mis: 1'b1, chk_data: 1'b0, data: 32'b0, alu: a, rd: rd};
            exp_q.push_back(e);
            return;
        end
        check("issue_stall", stall, 1'b1);
        for (int k = 0; k <= nwait; k++) begin
            @(posedge clk); #1;
            bus.ack   = (k == nwait);
            bus.rdata = (k == nwait) ? rdata : 32'hDEAD_BEEF;
            @(negedge clk);
            check("busy_req", bus.req, 1'b1);
            check("busy_we", bus.we, !ld);
            check("busy_addr", bus.addr, a & 32'hFFFF_FFFC);
            check("busy_be", bus.be, ld ? 4'b0000 : m_be(n, a));
            if (!ld) check("busy_wdata", bus.wdata, m_wd(n, sd));
            check("busy_stall", stall, !bus.ack);
            if (k == nwait) begin
                last_be = bus.be; last_wdata = bus.wdata; last_addr = bus.addr;
                e = '{at: cyc + 1, wr: wr & ld, um: ld, mis: 1'b0, chk_data: 1'b1,
                      data: ld ? m_ld(f, a, rdata) : 32'b0, alu: a, rd: rd};
                exp_q.push_back(e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; valid = 1'b0; mrd = 1'b0; mwr = 1'b0; wr_i = 1'b0; f3 = 3'd0;
        alu_i = 32'b0; sd_i = 32'b0; rd_i = 5'd0; bus.ack = 1'b0; bus.rdata = 32'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", bus.req, 1'b0);
        check("rst_we", bus.we, 1'b0);
        check("rst_be", bus.be, 4'b0);
        check("rst_addr", bus.addr, 32'b0);
        check("rst_wdata", bus.wdata, 32'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_wb", {use_mem, wr_o, mis_o, rd_o}, 32'b0);
        check("rst_wb_data", data_o | alu_o, 32'b0);
        @(posedge clk); #1;
        reset = 1'b0; run = 1'b1;

        // 1: ALU op passes in one cycle
        do_alu(32'h1234, 5'd5, 1'b1);
        do_idle(1);
        check("t1_alu", alu_o, 32'h1234);
        check("t1_rd", rd_o, 5'd5);
        do_alu(32'h0000_00AA, 5'd6, 1'b0);

        // 2: LB with three wait cycles
        do_mem(1, 3'b000, 32'h103, 32'h0, 1'b1, 5'd7, 3, 32'h80FF_0000);
        do_idle(1);
        check("t2_addr", last_addr, 32'h100);
        check("t2_data", data_o, 32'hFFFF_FF80);

        // 3: SH upper half, immediate ack
        do_mem(0, 3'b001, 32'h102, 32'hABCD_1234, 1'b1, 5'd8, 0, 32'h0);
        do_idle(1);
        check("t3_be", last_be, 4'b1100);
        check("t3_wdata", last_wdata, 32'h1234_1234);
        check("t3_write_reg", wr_o, 1'b0);

        // 4: LHU, then LHU followed back-to-back by LW
        do_mem(1, 3'b101, 32'h102, 32'h0, 1'b1, 5'd9, 1, 32'h8001_0000);
        do_idle(1);
        check("t4_lhu", data_o, 32'h0000_8001);
        do_mem(1, 3'b101, 32'h102, 32'h0, 1'b1, 5'd9, 0, 32'h8001_0000);
        do_mem(1, 3'b010, 32'h104, 32'h0, 1'b1, 5'd10, 0, 32'h1122_3344);
        do_idle(1);
        check("t4_lw", data_o, 32'h1122_3344);

        // extra lane patterns: SB top byte, SW, LH signed, LBU, illegal funct3
        do_mem(0, 3'b000, 32'h3, 32'h0000_005A, 1'b0, 5'd1, 1, 32'h0);
        do_mem(0, 3'b010, 32'h10, 32'hCAFE_F00D, 1'b0, 5'd2, 0, 32'h0);
        do_mem(1, 3'b001, 32'h200, 32'h0, 1'b1, 5'd3, 2, 32'h1234_8000);
        do_mem(1, 3'b100, 32'h201, 32'h0, 1'b1, 5'd4, 0, 32'h0000_F000);
        do_mem(1, 3'b011, 32'h20, 32'h0, 1'b1, 5'd11, 0, 32'h8765_4321);
        do_mem(0, 3'b111, 32'h24, 32'h0102_0304, 1'b0, 5'd12, 0, 32'h0);
        do_idle(1);
        check("x_sw_illegal_be", last_be, 4'b1111);

        // 5: reset while BUSY
        @(posedge clk); #1;
        valid = 1'b1; mrd = 1'b1; mwr = 1'b0; f3 = 3'b010; alu_i = 32'h300; rd_i = 5'd13;
        wr_i = 1'b1; bus.ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_req_before", bus.req, 1'b1);
        #2; reset = 1'b1; #1;
        check("t5_req", bus.req, 1'b0);
        check("t5_stall", stall, 1'b0);
        check("t5_bus", {bus.we, bus.be}, 32'b0);
        check("t5_wb", {use_mem, wr_o, mis_o, rd_o}, 32'b0);
        check("t5_wb_data", data_o | alu_o, 32'b0);
        @(posedge clk); #1;
        reset = 1'b0; valid = 1'b0;
        do_alu(32'hCAFE, 5'd3, 1'b1);
        do_idle(1);
        check("t5_post_alu", alu_o, 32'hCAFE);
        check("t5_post_wr", wr_o, 1'b1);

        // 6: misaligned word
        do_mem(1, 3'b010, 32'h101, 32'h0, 1'b1, 5'd14, 0, 32'hA5A5_5A5A);
        do_idle(1);
`ifdef MISALIGN_TRAP_EN
        check("t6_misalign", mis_o, 1'b1);
        check("t6_write_reg", wr_o, 1'b0);
`else
        check("t6_addr", last_addr, 32'h100);
        check("t6_data", data_o, 32'hA5A5_5A5A);
`endif
        do_idle(2);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
